// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_port_arbiter
//  Purpose  : Lets the IF fetch port and the MEM data port share one
//             single-ported SRAM with a 1-cycle read latency. Each cycle at
//             most one port is granted. The granted port drives the SRAM, and
//             the read data that returns one cycle later is flagged valid
//             only to the port that owns it.
//             A streak counter limits how many contested data grants can
//             occur in a row before fetch is forced to win.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    MAX_DATA_STREAK  consecutive contested data grants before fetch wins
//                     (legal range 1..15)
//    STAT_W           width of the statistics counters
//  Optional feature macro
//    ARB_STATS_EN     when defined, builds saturating conflict/stall counters.
//                     When undefined, the stat ports are tied to zero.
//  Ports
//    clk, resetn                       clock, asynchronous active-low reset
//    if_req/if_addr                    fetch read request
//    if_gnt/if_rvalid/if_rdata         fetch grant (comb) and read response
//    mem_req/mem_we/mem_addr/mem_wdata data request (mem_we == 0 -> read)
//    mem_gnt/mem_rvalid/mem_rdata      data grant (comb) and read response
//    sram_en/sram_we/sram_addr/sram_wdata  SRAM request drive
//    sram_rdata                        SRAM read data (1 cycle after read)
//    stat_conflict                     cycles with both requests high
//    stat_if_stall                     cycles with fetch requesting but not granted
// ============================================================================
module sram_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int STAT_W          = 32
) (
  input  logic              clk,
  input  logic              resetn,
  // fetch port
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  // data port
  input  logic              mem_req,
  input  logic [3:0]        mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [31:0]       mem_rdata,
  // SRAM side
  output logic              sram_en,
  output logic [3:0]        sram_we,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  // statistics
  output logic [STAT_W-1:0] stat_conflict,
  output logic [STAT_W-1:0] stat_if_stall
);

  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_DATA_STREAK);

  // Owner of the read data that arrives from the SRAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } own_t;

  own_t       r_resp_own;
  logic [3:0] r_streak;
  logic       w_force_if;
  logic       w_mem_read;

  // --------------------------------------------------------------------------
  // Grant logic: data normally wins. Once the contested data streak reaches
  // the limit, a pending fetch takes the slot.
  // --------------------------------------------------------------------------
  assign w_force_if = if_req & (r_streak == C_MAX_STREAK);
  assign mem_gnt    = mem_req & ~w_force_if;
  assign if_gnt     = if_req & ~mem_gnt;
  assign w_mem_read = mem_gnt & (mem_we == 4'b0000);

  // --------------------------------------------------------------------------
  // SRAM drive: muxed from the granted port. It is zero when idle, so the
  // SRAM bus does not toggle without an enable.
  // --------------------------------------------------------------------------
  assign sram_en = if_gnt | mem_gnt;

  always_comb begin
    sram_we    = 4'b0000;
    sram_addr  = 32'd0;
    sram_wdata = 32'd0;
    if (mem_gnt) begin
      sram_we    = mem_we;
      sram_addr  = mem_addr;
      sram_wdata = mem_wdata;
    end else if (if_gnt) begin
      sram_addr  = if_addr;
    end
  end

  // --------------------------------------------------------------------------
  // Response owner and data streak. Writes leave the owner at NONE, so they
  // never produce an rvalid pulse.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_own <= OWN_NONE;
      r_streak   <= 4'd0;
    end else begin
      if (if_gnt) begin
        r_resp_own <= OWN_IF;
      end else if (w_mem_read) begin
        r_resp_own <= OWN_MEM;
      end else begin
        r_resp_own <= OWN_NONE;
      end

      // Only data grants made while fetch was waiting count toward the
      // streak. The streak cannot pass the limit because reaching the limit
      // blocks further data grants while if_req is high.
      if (if_gnt || !if_req) begin
        r_streak <= 4'd0;
      end else if (mem_gnt) begin
        r_streak <= r_streak + 4'd1;
      end
    end
  end

  assign if_rvalid  = (r_resp_own == OWN_IF);
  assign mem_rvalid = (r_resp_own == OWN_MEM);
  assign if_rdata   = sram_rdata;
  assign mem_rdata  = sram_rdata;

  // --------------------------------------------------------------------------
  // Optional statistics counters (saturating).
  // --------------------------------------------------------------------------
`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_conflict;
  logic [STAT_W-1:0] r_stat_if_stall;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_conflict <= '0;
      r_stat_if_stall <= '0;
    end else begin
      if (if_req && mem_req && (r_stat_conflict != {STAT_W{1'b1}})) begin
        r_stat_conflict <= r_stat_conflict + 1'b1;
      end
      if (if_req && !if_gnt && (r_stat_if_stall != {STAT_W{1'b1}})) begin
        r_stat_if_stall <= r_stat_if_stall + 1'b1;
      end
    end
  end

  assign stat_conflict = r_stat_conflict;
  assign stat_if_stall = r_stat_if_stall;
`else
  assign stat_conflict = '0;
  assign stat_if_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_port_arbiter
//  Purpose  : Directed self-checking bench for sram_port_arbiter. It contains
//             a small byte-writable SRAM model with a 1-cycle read latency.
//             Define ARB_STATS_EN here to expect live statistics counters.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_port_arbiter;

  logic        clk;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [31:0] stat_conflict;
  logic [31:0] stat_if_stall;

  int n_checks;
  int n_pass;

  sram_port_arbiter #(
    .MAX_DATA_STREAK(4),
    .STAT_W(32)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_gnt(if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata(if_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata),
    .sram_en(sram_en),
    .sram_we(sram_we),
    .sram_addr(sram_addr),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .stat_conflict(stat_conflict),
    .stat_if_stall(stat_if_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: 256 words, indexed by address bits [9:2]
  logic [31:0] mem [256];

  function automatic logic [31:0] init_word(input int idx);
    return 32'hC0DE_0000 + 32'(idx) * 32'h0000_0101;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    sram_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'b0000) begin
        sram_rdata <= mem[sram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (sram_we[b]) mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic exp_m;
  logic prev_m;
  int   n_rv;

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    resetn    = 1'b0;
    if_req    = 1'b0;
    if_addr   = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;

    // ---------------- reset state ----------------
    #1;
    check_eq("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check_eq("rst_mem_rvalid", 32'(mem_rvalid), 32'd0);
    check_eq("rst_sram_en", 32'(sram_en), 32'd0);
    check_eq("rst_stat_conflict", stat_conflict, 32'd0);
    check_eq("rst_stat_if_stall", stat_if_stall, 32'd0);
    if_req = 1'b1;
    #1;
    check_eq("rst_if_gnt_comb", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    #10 resetn = 1'b1;       // release away from the clock edge
    tick();

    // ---------------- test 1: fetch only, 3 cycles ----------------
    if_req = 1'b1; if_addr = 32'h1c00_0000;
    #1;
    check_eq("t1_if_gnt0", 32'(if_gnt), 32'd1);
    check_eq("t1_sram_addr0", sram_addr, 32'h1c00_0000);
    check_eq("t1_sram_we0", 32'(sram_we), 32'd0);
    tick();
    if_addr = 32'h1c00_0004;
    #1;
    check_eq("t1_if_gnt1", 32'(if_gnt), 32'd1);
    check_eq("t1_if_rvalid1", 32'(if_rvalid), 32'd1);
    check_eq("t1_if_rdata1", if_rdata, init_word(0));
    tick();
    if_addr = 32'h1c00_0008;
    #1;
    check_eq("t1_if_gnt2", 32'(if_gnt), 32'd1);
    check_eq("t1_if_rvalid2", 32'(if_rvalid), 32'd1);
    check_eq("t1_if_rdata2", if_rdata, init_word(1));
    tick();
    if_req = 1'b0;
    #1;
    check_eq("t1_if_rvalid3", 32'(if_rvalid), 32'd1);
    check_eq("t1_if_rdata3", if_rdata, init_word(2));
    check_eq("t1_idle_sram_en", 32'(sram_en), 32'd0);
    check_eq("t1_idle_sram_addr", sram_addr, 32'd0);
    tick();
    #1;
    check_eq("t1_if_rvalid_end", 32'(if_rvalid), 32'd0);

    // ---------------- test 2: data write then read ----------------
    mem_req = 1'b1; mem_we = 4'hf; mem_addr = 32'h100; mem_wdata = 32'hdead_beef;
    #1;
    check_eq("t2_mem_gnt_w", 32'(mem_gnt), 32'd1);
    check_eq("t2_sram_we", 32'(sram_we), 32'hf);
    check_eq("t2_sram_wdata", sram_wdata, 32'hdead_beef);
    check_eq("t2_sram_addr", sram_addr, 32'h100);
    tick();
    mem_we = 4'h0; mem_wdata = 32'd0;
    #1;
    check_eq("t2_no_rvalid_after_w", 32'(mem_rvalid | if_rvalid), 32'd0);
    check_eq("t2_mem_gnt_r", 32'(mem_gnt), 32'd1);
    check_eq("t2_sram_we_r", 32'(sram_we), 32'd0);
    tick();
    mem_req = 1'b0;
    #1;
    check_eq("t2_mem_rvalid", 32'(mem_rvalid), 32'd1);
    check_eq("t2_mem_rdata", mem_rdata, 32'hdead_beef);
    tick();
    #1;
    check_eq("t2_mem_rvalid_end", 32'(mem_rvalid), 32'd0);

    // ---------------- test 3: both requesting for 10 cycles ----------------
    resetn = 1'b0;           // clear statistics before the contested run
    #2 resetn = 1'b1;
    tick();
    n_rv   = 0;
    prev_m = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) begin
        if_req = 1'b1; if_addr = 32'h1c00_0000;
        mem_req = 1'b1; mem_we = 4'h0; mem_addr = 32'h100;
      end else begin
        if_req = 1'b0; mem_req = 1'b0;
      end
      #1;
      exp_m = ((i % 5) != 4);
      if (i < 10) begin
        check_eq($sformatf("t3_mem_gnt%0d", i), 32'(mem_gnt), 32'(exp_m));
        check_eq($sformatf("t3_if_gnt%0d", i), 32'(if_gnt), 32'(!exp_m));
        check_eq($sformatf("t3_sram_addr%0d", i), sram_addr, exp_m ? 32'h100 : 32'h1c00_0000);
      end
      if (i > 0) begin
        check_eq($sformatf("t3_mem_rvalid%0d", i), 32'(mem_rvalid), 32'(prev_m));
        check_eq($sformatf("t3_if_rvalid%0d", i), 32'(if_rvalid), 32'(!prev_m));
        check_eq($sformatf("t3_rdata%0d", i), mem_rdata, prev_m ? 32'hdead_beef : init_word(0));
        n_rv += int'(mem_rvalid) + int'(if_rvalid);
      end
      prev_m = exp_m;
      tick();
    end
    check_eq("t3_rvalid_total", 32'(n_rv), 32'd10);
`ifdef ARB_STATS_EN
    check_eq("t3_stat_conflict", stat_conflict, 32'd10);
    check_eq("t3_stat_if_stall", stat_if_stall, 32'd8);
`else
    check_eq("t3_stat_conflict_off", stat_conflict, 32'd0);
    check_eq("t3_stat_if_stall_off", stat_if_stall, 32'd0);
`endif

    // ---------------- test 4: reset drops in-flight read ----------------
    if_req = 1'b1; if_addr = 32'h1c00_0000;
    mem_req = 1'b1; mem_we = 4'h0; mem_addr = 32'h100;
    #1;
    check_eq("t4_mem_gnt0", 32'(mem_gnt), 32'd1);
    tick();
    #1;
    check_eq("t4_mem_gnt1", 32'(mem_gnt), 32'd1);
    #3;                      // mid-cycle, before the response edge
    resetn = 1'b0;
    #1;
    check_eq("t4_rvalid_in_reset", 32'(mem_rvalid), 32'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    check_eq("t4_mem_rvalid_after", 32'(mem_rvalid), 32'd0);
    check_eq("t4_if_rvalid_after", 32'(if_rvalid), 32'd0);
    // streak must restart at 0: four data grants before fetch wins
    for (int k = 0; k < 5; k++) begin
      if (k > 0) #1;
      check_eq($sformatf("t4_streak_mem_gnt%0d", k), 32'(mem_gnt), 32'(k < 4));
      check_eq($sformatf("t4_streak_if_gnt%0d", k), 32'(if_gnt), 32'(k == 4));
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick();

    // ---------------- test 5: contested data writes ----------------
    if_req = 1'b1; if_addr = 32'h1c00_0004;
    mem_req = 1'b1; mem_we = 4'hf; mem_addr = 32'h200; mem_wdata = 32'h1122_3344;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq($sformatf("t5_mem_gnt%0d", k), 32'(mem_gnt), 32'(k < 4));
      check_eq($sformatf("t5_if_gnt%0d", k), 32'(if_gnt), 32'(k == 4));
      if (k == 0) check_eq("t5_sram_we", 32'(sram_we), 32'hf);
      if (k > 0) begin
        check_eq($sformatf("t5_mem_rvalid%0d", k), 32'(mem_rvalid), 32'd0);
        check_eq($sformatf("t5_if_rvalid%0d", k), 32'(if_rvalid), 32'd0);
      end
      tick();
    end
    if_req = 1'b0; mem_req = 1'b0; mem_we = 4'h0;
    #1;
    check_eq("t5_if_rvalid_final", 32'(if_rvalid), 32'd1);
    check_eq("t5_if_rdata_final", if_rdata, init_word(1));
    check_eq("t5_mem_rvalid_final", 32'(mem_rvalid), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
